alu_acc_writer: RTL and testbench

- Sequential ALU front end that reads the accumulator output `acc_data` and the memory-buffer operand `mbr_data`.
- Computes the result and writes it back into ACC by driving `alu2acc` with a one-cycle `acc_alu_io_rw` write strobe.
- Acts as the write-side master of the ALU/ACC interface.
- Single-cycle logic ops; iterative shift-add multiply; start/done handshake toward the control unit.

---
 rtl/alu_acc_writer.sv | 190 +++++++++++++++++++
 tb/tb_alu_acc_writer.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/alu_acc_writer.sv
// Sequential ALU that computes from ACC/MBR operands and writes the result back into ACC.
// Latency: start-sample edge to ACC write edge is 2 cycles, or MUL_CYCLES+1 cycles for MPY.
// Backpressure: none; start is accepted only in IDLE, and start while busy is dropped.
//
// Ports:
//   clk, rst_n          clock and async active-low reset
//   start, op           operation request and opcode from the control unit
//   acc_data, mbr_data  operand A (ACC) and operand B (MBR)
//   alu2acc             result toward ACC, held outside the write-back cycle
//   acc_alu_io_rw       one-cycle ACC write strobe (legal ops only)
//   busy, done, illegal handshake toward the control unit
//   flag_z, flag_c      registered zero and carry/borrow/shift-out/overflow flags
module alu_acc_writer #(
   parameter int WIDTH      = 16,
   parameter int MUL_CYCLES = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] acc_data,
   input  logic [WIDTH-1:0] mbr_data,
   output logic [WIDTH-1:0] alu2acc,
   output logic             acc_alu_io_rw,
   output logic             busy,
   output logic             done,
   output logic             illegal,
   output logic             flag_z,
   output logic             flag_c
);

   localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(MUL_CYCLES - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_WB   = 2'd2;

   localparam logic [3:0] OP_ADD = 4'b0001;
   localparam logic [3:0] OP_SUB = 4'b0010;
   localparam logic [3:0] OP_AND = 4'b0011;
   localparam logic [3:0] OP_OR  = 4'b0100;
   localparam logic [3:0] OP_NOT = 4'b0101;
   localparam logic [3:0] OP_SHL = 4'b0110;
   localparam logic [3:0] OP_SHR = 4'b0111;
   localparam logic [3:0] OP_MPY = 4'b1000;

   logic [1:0]         state_q, state_d;
   logic [3:0]         op_q, op_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [2*WIDTH-1:0] prod_q, prod_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [WIDTH-1:0]   alu2acc_q, alu2acc_d;
   logic               rw_q, rw_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               illegal_q, illegal_d;
   logic               flag_z_q, flag_z_d;
   logic               flag_c_q, flag_c_d;

   // Single-cycle datapath; the extra top bit carries the ADD carry / SUB borrow.
   logic [WIDTH:0]     logic_res;
   logic               logic_legal;
   logic [2*WIDTH-1:0] prod_nxt;

   always_comb begin
      logic_res   = '0;
      logic_legal = 1'b1;
      case (op_q)
         OP_ADD:  logic_res = {1'b0, a_q} + {1'b0, b_q};
         OP_SUB:  logic_res = {1'b0, a_q} - {1'b0, b_q};
         OP_AND:  logic_res = {1'b0, a_q & b_q};
         OP_OR:   logic_res = {1'b0, a_q | b_q};
         OP_NOT:  logic_res = {1'b0, ~a_q};
         OP_SHL:  logic_res = {a_q[WIDTH-1], a_q[WIDTH-2:0], 1'b0};
         OP_SHR:  logic_res = {a_q[0], 1'b0, a_q[WIDTH-1:1]};
         default: logic_legal = 1'b0;
      endcase
   end

   // One multiplier bit per cycle, LSB first: add A shifted to that bit's weight.
   assign prod_nxt = prod_q + (b_q[cnt_q] ? ({{WIDTH{1'b0}}, a_q} << cnt_q) : '0);

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      a_d       = a_q;
      b_d       = b_q;
      prod_d    = prod_q;
      cnt_d     = cnt_q;
      alu2acc_d = alu2acc_q;
      rw_d      = 1'b0;
      busy_d    = busy_q;
      done_d    = 1'b0;
      illegal_d = 1'b0;
      flag_z_d  = flag_z_q;
      flag_c_d  = flag_c_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               op_d    = op;
               a_d     = acc_data;
               b_d     = mbr_data;
               prod_d  = '0;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = S_CALC;
            end
         end
         S_CALC: begin
            // Output registers are loaded on the edge entering WB so that the
            // strobe, data and flags are all valid during the WB cycle itself.
            if (op_q == OP_MPY) begin
               prod_d = prod_nxt;
               cnt_d  = cnt_q + 1'b1;
               if (cnt_q == CNT_LAST) begin
                  state_d   = S_WB;
                  alu2acc_d = prod_nxt[WIDTH-1:0];
                  flag_z_d  = (prod_nxt[WIDTH-1:0] == '0);
                  flag_c_d  = |prod_nxt[2*WIDTH-1:WIDTH];
                  rw_d      = 1'b1;
                  done_d    = 1'b1;
               end
            end else begin
               state_d = S_WB;
               done_d  = 1'b1;
               if (logic_legal) begin
                  alu2acc_d = logic_res[WIDTH-1:0];
                  flag_z_d  = (logic_res[WIDTH-1:0] == '0);
                  flag_c_d  = logic_res[WIDTH];
                  rw_d      = 1'b1;
               end else begin
                  illegal_d = 1'b1;
               end
            end
         end
         S_WB: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         op_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         prod_q    <= '0;
         cnt_q     <= '0;
         alu2acc_q <= '0;
         rw_q      <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         illegal_q <= 1'b0;
         flag_z_q  <= 1'b0;
         flag_c_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         a_q       <= a_d;
         b_q       <= b_d;
         prod_q    <= prod_d;
         cnt_q     <= cnt_d;
         alu2acc_q <= alu2acc_d;
         rw_q      <= rw_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         illegal_q <= illegal_d;
         flag_z_q  <= flag_z_d;
         flag_c_q  <= flag_c_d;
      end
   end

   assign alu2acc       = alu2acc_q;
   assign acc_alu_io_rw = rw_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign illegal       = illegal_q;
   assign flag_z        = flag_z_q;
   assign flag_c        = flag_c_q;

endmodule

// File: tb/tb_alu_acc_writer.sv
// Directed bench for alu_acc_writer: hand-computed results, latency and strobe counts.
// Latency: each op is observed from its start edge until done plus one idle cycle.
// Backpressure: exercises start spam during a multiply and an async reset mid-multiply.
module tb_alu_acc_writer;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [3:0]  op;
   logic [15:0] acc_data;
   logic [15:0] mbr_data;
   logic [15:0] alu2acc;
   logic        acc_alu_io_rw;
   logic        busy;
   logic        done;
   logic        illegal;
   logic        flag_z;
   logic        flag_c;

   int checks;
   int failures;

   alu_acc_writer #(.WIDTH(16), .MUL_CYCLES(16)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .op            (op),
      .acc_data      (acc_data),
      .mbr_data      (mbr_data),
      .alu2acc       (alu2acc),
      .acc_alu_io_rw (acc_alu_io_rw),
      .busy          (busy),
      .done          (done),
      .illegal       (illegal),
      .flag_z        (flag_z),
      .flag_c        (flag_c)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Issues one op at a negedge and follows it to done, then one idle cycle more.
   // spam=1 keeps start high through the op and changes acc_data at cycle 8.
   task automatic run(input string tag, input logic [3:0] o, input logic [15:0] a,
                      input logic [15:0] b, input bit spam, input int exp_lat,
                      input logic [15:0] exp_res, input bit exp_c, input bit exp_z,
                      input bit exp_ill);
      int  k;
      int  nrw;
      bit  seen_done;
      bit  ill_at_done;
      k = 0; nrw = 0; seen_done = 0; ill_at_done = 0;
      op = o; acc_data = a; mbr_data = b; start = 1'b1;
      while (!seen_done && k < 40) begin
         @(negedge clk);
         k++;
         if (k == 1) check({tag, "_busy_rise"}, busy, 1);
         if (!spam) start = 1'b0;
         if (spam && k == 8) acc_data = 16'hFFFF;
         if (acc_alu_io_rw) nrw++;
         if (done) begin
            seen_done   = 1;
            ill_at_done = illegal;
            start       = 1'b0;
         end
      end
      check({tag, "_done_seen"}, seen_done, 1);
      check({tag, "_latency"}, k, exp_lat);
      check({tag, "_illegal"}, ill_at_done, exp_ill);
      @(negedge clk);
      if (acc_alu_io_rw) nrw++;
      check({tag, "_rw_count"}, nrw, exp_ill ? 0 : 1);
      check({tag, "_busy_after"}, busy, 0);
      check({tag, "_done_after"}, done, 0);
      check({tag, "_result"}, alu2acc, exp_res);
      check({tag, "_flag_c"}, flag_c, exp_c);
      check({tag, "_flag_z"}, flag_z, exp_z);
   endtask

   initial begin
      int nrw;
      checks = 0; failures = 0;
      rst_n = 1'b0; start = 1'b0; op = 4'd0; acc_data = '0; mbr_data = '0;
      #12;
      check("rst_alu2acc", alu2acc, 0);
      check("rst_rw", acc_alu_io_rw, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_illegal", illegal, 0);
      check("rst_flag_z", flag_z, 0);
      check("rst_flag_c", flag_c, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      //        tag        op      A         B         spam lat res       c  z  ill
      run("add",      4'b0001, 16'h7FFF, 16'h0001, 0, 2,  16'h8000, 0, 0, 0);
      run("sub_brw",  4'b0010, 16'h0003, 16'h0005, 0, 2,  16'hFFFE, 1, 0, 0);
      run("and",      4'b0011, 16'hF0F0, 16'h3C3C, 0, 2,  16'h3030, 0, 0, 0);
      run("sub_eq",   4'b0010, 16'h1234, 16'h1234, 0, 2,  16'h0000, 0, 1, 0);
      run("or",       4'b0100, 16'h1200, 16'h0034, 0, 2,  16'h1234, 0, 0, 0);
      run("shl",      4'b0110, 16'h8001, 16'h5555, 0, 2,  16'h0002, 1, 0, 0);
      run("illegal",  4'b1111, 16'h0000, 16'h0000, 0, 2,  16'h0002, 1, 0, 1);
      run("not",      4'b0101, 16'h00FF, 16'hAAAA, 0, 2,  16'hFF00, 0, 0, 0);
      run("shr",      4'b0111, 16'h0001, 16'h0000, 0, 2,  16'h0000, 1, 1, 0);
      run("mpy",      4'b1000, 16'h0012, 16'h0034, 0, 17, 16'h03A8, 0, 0, 0);
      run("mpy_ovf",  4'b1000, 16'h0100, 16'h0100, 0, 17, 16'h0000, 1, 1, 0);
      run("mpy_spam", 4'b1000, 16'h0003, 16'h0005, 1, 17, 16'h000F, 0, 0, 0);

      // Async reset during multiply cycle 8: outputs clear at once, no strobe.
      op = 4'b1000; acc_data = 16'h0007; mbr_data = 16'h0009; start = 1'b1;
      nrw = 0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         start = 1'b0;
         if (acc_alu_io_rw) nrw++;
      end
      #2 rst_n = 1'b0;
      #1;
      check("arst_busy", busy, 0);
      check("arst_alu2acc", alu2acc, 0);
      check("arst_rw", acc_alu_io_rw, 0);
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (k == 2) rst_n = 1'b1;
         if (acc_alu_io_rw) nrw++;
      end
      check("arst_no_strobe", nrw, 0);
      check("arst_busy_idle", busy, 0);
      run("add_post", 4'b0001, 16'h0001, 16'h0002, 0, 2, 16'h0003, 0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
